vga_raster_gen: RTL and testbench

VGA_RASTER_GEN -- requirements
Module: vga_raster_gen

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_raster_gen_if.sv | 34 +++
 rtl/vga_delay_line.sv | 30 +++
 rtl/vga_raster_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_raster_gen.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals and pipeline latency for the raster generator.
package vga_pkg;

    function automatic int line_total(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL_DEF = line_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = line_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    // Counters -> coordinate register -> producer register -> DAC register.
    localparam int PIPE_LATENCY = 3;
    localparam int CNT_W        = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_raster_gen_if.sv
// Bundle of the raster generator's producer-side and DAC-side signals.
interface vga_raster_gen_if;
    import vga_pkg::*;

    logic [7:0]       VGA_R_in;
    logic [7:0]       VGA_G_in;
    logic [7:0]       VGA_B_in;
    logic [CNT_W-1:0] i;
    logic [CNT_W-1:0] j;
    logic             printing;
    logic             frame_tick;
    logic             VGA_HS;
    logic             VGA_VS;
    logic             VGA_BLANK_N;
    logic             VGA_SYNC_N;
    logic [7:0]       VGA_R;
    logic [7:0]       VGA_G;
    logic [7:0]       VGA_B;

    modport master (
        input  VGA_R_in, VGA_G_in, VGA_B_in,
        output i, j, printing, frame_tick,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output VGA_R_in, VGA_G_in, VGA_B_in,
        input  i, j, printing, frame_tick,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input  VGA_R, VGA_G, VGA_B
    );

endinterface

// File: rtl/vga_delay_line.sv
// N-stage shift register with an asynchronous, parameterised reset value.
module vga_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             VGA_CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_reg[s] <= RESET_VALUE;
            end
        end else begin
            stage_reg[0] <= din;
            for (int s = 1; s < STAGES; s++) begin
                stage_reg[s] <= stage_reg[s-1];
            end
        end
    end

    assign dout = stage_reg[STAGES-1];

endmodule

// File: rtl/vga_raster_gen.sv
// VGA raster generator: counters, coordinate stage for a 1-cycle producer, DAC stage and aligned syncs.
// Build option VGA_TEST_PATTERN_EN replaces producer colour with eight vertical colour bars.
module vga_raster_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic             VGA_CLK,
    input  logic             reset,
    input  logic [7:0]       VGA_R_in,
    input  logic [7:0]       VGA_G_in,
    input  logic [7:0]       VGA_B_in,
    output logic [CNT_W-1:0] i,
    output logic [CNT_W-1:0] j,
    output logic             printing,
    output logic             frame_tick,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B
);

    localparam int H_TOTAL      = line_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = line_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_STOP  = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_STOP  = V_SYNC_START + V_SYNC;

    logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
    logic [CNT_W-1:0] v_cnt_reg, v_cnt_next;
    logic             h_wrap, v_last;
    logic             visible, hsync, vsync, frame_start;

    always_comb begin
        h_wrap      = (h_cnt_reg == CNT_W'(H_TOTAL - 1));
        v_last      = (v_cnt_reg == CNT_W'(V_TOTAL - 1));
        h_cnt_next  = h_wrap ? '0 : h_cnt_reg + CNT_W'(1);
        v_cnt_next  = v_cnt_reg;
        if (h_wrap) begin
            v_cnt_next = v_last ? '0 : v_cnt_reg + CNT_W'(1);
        end
        visible     = (h_cnt_reg < CNT_W'(H_VISIBLE)) && (v_cnt_reg < CNT_W'(V_VISIBLE));
        hsync       = (h_cnt_reg >= CNT_W'(H_SYNC_START)) && (h_cnt_reg < CNT_W'(H_SYNC_STOP));
        vsync       = (v_cnt_reg >= CNT_W'(V_SYNC_START)) && (v_cnt_reg < CNT_W'(V_SYNC_STOP));
        frame_start = (h_cnt_reg == '0) && (v_cnt_reg == CNT_W'(V_VISIBLE));
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    // Coordinate stage offered to the producer; raw counter values outside the visible area.
    logic [CNT_W-1:0] i_reg, j_reg;
    logic             printing_reg, frame_tick_reg, printing_d_reg;

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            i_reg          <= '0;
            j_reg          <= '0;
            printing_reg   <= 1'b0;
            frame_tick_reg <= 1'b0;
            printing_d_reg <= 1'b0;
        end else begin
            i_reg          <= v_cnt_reg;
            j_reg          <= h_cnt_reg;
            printing_reg   <= visible;
            frame_tick_reg <= frame_start;
            printing_d_reg <= printing_reg;
        end
    end

    assign i          = i_reg;
    assign j          = j_reg;
    assign printing   = printing_reg;
    assign frame_tick = frame_tick_reg;

    logic [2:0][7:0] src_rgb;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;

    logic [2:0]      bar_idx;
    logic [2:0][7:0] pattern_reg;
    logic            unused_rgb_in;

    assign unused_rgb_in = ^{VGA_R_in, VGA_G_in, VGA_B_in};
    assign bar_idx       = 3'(j_reg / CNT_W'(BAR_W));

    // Internal stand-in for the producer register so bars keep the normal latency.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            pattern_reg <= '0;
        end else begin
            pattern_reg <= {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
        end
    end

    assign src_rgb = pattern_reg;
`else
    assign src_rgb = {VGA_R_in, VGA_G_in, VGA_B_in};
`endif

    logic [2:0][7:0] dac_rgb;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dac
        logic [7:0] dac_reg;

        always_ff @(posedge VGA_CLK or posedge reset) begin
            if (reset) begin
                dac_reg <= '0;
            end else begin
                dac_reg <= printing_d_reg ? src_rgb[gi] : 8'h00;
            end
        end

        assign dac_rgb[gi] = dac_reg;
    end

    assign VGA_R = dac_rgb[2];
    assign VGA_G = dac_rgb[1];
    assign VGA_B = dac_rgb[0];

    // Syncs are carried active-low so the cleared state is the idle level.
    logic [2:0] sync_raw, sync_dly;

    assign sync_raw = {~hsync, ~vsync, visible};

    vga_delay_line #(
        .WIDTH       (3),
        .STAGES      (PIPE_LATENCY),
        .RESET_VALUE (3'b110)
    ) u_sync_dly (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .din     (sync_raw),
        .dout    (sync_dly)
    );

    assign VGA_HS      = sync_dly[2];
    assign VGA_VS      = sync_dly[1];
    assign VGA_BLANK_N = sync_dly[0];
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_raster_gen.sv
// Scoreboard bench for vga_raster_gen: reference model driven by cycle count since reset release.
// Build with VGA_TEST_PATTERN_EN to check the colour-bar variant.
module tb_vga_raster_gen;

    // Reduced raster geometry so several whole frames fit in a short run.
    localparam int HV = 160, HFP = 8, HSW = 16, HBP = 16;
    localparam int VV = 24,  VFP = 3, VSW = 2,  VBP = 4;
    localparam int HT = HV + HFP + HSW + HBP;
    localparam int VT = VV + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int LAT = 3;
    localparam int M_RAND = 0, M_PROD = 1, M_FF = 2;
    localparam int RST_TARGET = 20 * HT + 190;

    typedef struct {
        int         edge_no;
        logic [9:0] i, j;
        logic       pr, ft, hs, vs, bn;
        logic [7:0] r, g, b;
    } exp_t;

    logic VGA_CLK;
    logic reset;
    int   edge_cnt;
    int   vectors;
    int   miscompares;
    exp_t exp_q[$];
    logic [9:0] prev_i, prev_j;

    vga_raster_gen_if vif();

    vga_raster_gen #(
        .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP)
    ) dut (
        .VGA_CLK     (VGA_CLK),
        .reset       (reset),
        .VGA_R_in    (vif.VGA_R_in),
        .VGA_G_in    (vif.VGA_G_in),
        .VGA_B_in    (vif.VGA_B_in),
        .i           (vif.i),
        .j           (vif.j),
        .printing    (vif.printing),
        .frame_tick  (vif.frame_tick),
        .VGA_HS      (vif.VGA_HS),
        .VGA_VS      (vif.VGA_VS),
        .VGA_BLANK_N (vif.VGA_BLANK_N),
        .VGA_SYNC_N  (vif.VGA_SYNC_N),
        .VGA_R       (vif.VGA_R),
        .VGA_G       (vif.VGA_G),
        .VGA_B       (vif.VGA_B)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    // Rising edges seen since the last reset release.
    always @(posedge VGA_CLK or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // Expected outputs just after rising edge e, given the colour input sampled at that edge.
    function automatic exp_t model(input int e, input int mode, input logic [7:0] ri, gi, bi);
        exp_t x;
        int p0, p3, hx, vy, k;
        logic vis;
        x.edge_no = e;
        p0   = (e - 1) % FRAME;
        x.j  = 10'(p0 % HT);
        x.i  = 10'(p0 / HT);
        x.pr = (p0 % HT < HV) && (p0 / HT < VV);
        x.ft = (p0 % HT == 0) && (p0 / HT == VV);
        x.r = 8'h00; x.g = 8'h00; x.b = 8'h00;
        x.hs = 1'b1; x.vs = 1'b1; x.bn = 1'b0;
        if (e >= LAT) begin
            p3   = (e - LAT) % FRAME;
            hx   = p3 % HT;
            vy   = p3 / HT;
            vis  = (hx < HV) && (vy < VV);
            x.hs = !(hx >= HV + HFP && hx < HV + HFP + HSW);
            x.vs = !(vy >= VV + VFP && vy < VV + VFP + VSW);
            x.bn = vis;
            if (vis) begin
`ifdef VGA_TEST_PATTERN_EN
                k   = hx / (HV / 8);
                x.r = ((k & 4) != 0) ? 8'hFF : 8'h00;
                x.g = ((k & 2) != 0) ? 8'hFF : 8'h00;
                x.b = ((k & 1) != 0) ? 8'hFF : 8'h00;
`else
                k = 0;
                if (mode == M_PROD) begin
                    x.r = 8'(vy); x.g = 8'(hx); x.b = 8'h55;
                end else begin
                    x.r = ri; x.g = gi; x.b = bi;
                end
`endif
            end
        end
        return x;
    endfunction

    // Stimulus: one producer cycle per call step; expectation queued for the next edge.
    task automatic run(input int n, input int mode);
        logic [7:0] r, g, b;
        for (int k = 0; k < n; k++) begin
            case (mode)
                M_PROD: begin r = prev_i[7:0]; g = prev_j[7:0]; b = 8'h55; end
                M_FF:   begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
                default: begin
                    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
                end
            endcase
            prev_i = vif.i;
            prev_j = vif.j;
            vif.VGA_R_in = r;
            vif.VGA_G_in = g;
            vif.VGA_B_in = b;
            exp_q.push_back(model(edge_cnt + 1, mode, r, g, b));
            @(negedge VGA_CLK);
        end
    endtask

    task automatic check_reset(input string tag);
        vectors++;
        if (vif.i !== 10'd0 || vif.j !== 10'd0 || vif.printing !== 1'b0 || vif.frame_tick !== 1'b0 ||
            vif.VGA_HS !== 1'b1 || vif.VGA_VS !== 1'b1 || vif.VGA_BLANK_N !== 1'b0 ||
            vif.VGA_SYNC_N !== 1'b0 || {vif.VGA_R, vif.VGA_G, vif.VGA_B} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_%s: got i=%0d j=%0d pr=%b ft=%b hs=%b vs=%b bn=%b sn=%b rgb=%h_%h_%h, want all idle",
                     tag, vif.i, vif.j, vif.printing, vif.frame_tick, vif.VGA_HS, vif.VGA_VS,
                     vif.VGA_BLANK_N, vif.VGA_SYNC_N, vif.VGA_R, vif.VGA_G, vif.VGA_B);
        end
    endtask

    // Monitor: pops the entry belonging to the current edge and compares every output.
    always @(negedge VGA_CLK) begin
        exp_t ex;
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
                ex = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_edge: entry for edge %0d unchecked at edge %0d", ex.edge_no, edge_cnt);
            end
            if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
                ex = exp_q.pop_front();
                vectors++;
                if (vif.i !== ex.i || vif.j !== ex.j || vif.printing !== ex.pr || vif.frame_tick !== ex.ft ||
                    vif.VGA_HS !== ex.hs || vif.VGA_VS !== ex.vs || vif.VGA_BLANK_N !== ex.bn ||
                    vif.VGA_SYNC_N !== 1'b0 || vif.VGA_R !== ex.r || vif.VGA_G !== ex.g || vif.VGA_B !== ex.b) begin
                    miscompares++;
                    $display("FAIL pixel edge=%0d: got i=%0d j=%0d pr=%b ft=%b hs=%b vs=%b bn=%b rgb=%h_%h_%h, want i=%0d j=%0d pr=%b ft=%b hs=%b vs=%b bn=%b rgb=%h_%h_%h",
                             edge_cnt, vif.i, vif.j, vif.printing, vif.frame_tick, vif.VGA_HS, vif.VGA_VS,
                             vif.VGA_BLANK_N, vif.VGA_R, vif.VGA_G, vif.VGA_B,
                             ex.i, ex.j, ex.pr, ex.ft, ex.hs, ex.vs, ex.bn, ex.r, ex.g, ex.b);
                end
            end
        end
    end

    // Frame-level timing: sync widths, HS pulses per frame, frame and tick periods.
    int  hs_len, vs_len, hs_count, vs_edge, ft_edge;
    bit  in_hs, in_vs, have_vs, have_ft;

    always @(negedge VGA_CLK) begin
        if (reset) begin
            in_hs = 0; in_vs = 0; have_vs = 0; have_ft = 0; hs_count = 0;
        end else begin
            if (!vif.VGA_HS) begin
                if (!in_hs) begin in_hs = 1; hs_len = 0; hs_count++; end
                hs_len++;
            end else if (in_hs) begin
                in_hs = 0;
                vectors++;
                if (hs_len != HSW) begin
                    miscompares++;
                    $display("FAIL hs_width: got %0d clocks, want %0d", hs_len, HSW);
                end
            end
            if (!vif.VGA_VS) begin
                if (!in_vs) begin
                    in_vs = 1; vs_len = 0;
                    if (have_vs) begin
                        vectors++;
                        if (edge_cnt - vs_edge != FRAME || hs_count != VT + 1) begin
                            miscompares++;
                            $display("FAIL frame_period: got %0d clocks %0d hs pulses, want %0d clocks %0d hs pulses",
                                     edge_cnt - vs_edge, hs_count - 1, FRAME, VT);
                        end
                    end
                    have_vs = 1; vs_edge = edge_cnt; hs_count = 1;
                end
                vs_len++;
            end else if (in_vs) begin
                in_vs = 0;
                vectors++;
                if (vs_len != VSW * HT) begin
                    miscompares++;
                    $display("FAIL vs_width: got %0d clocks, want %0d", vs_len, VSW * HT);
                end
            end
            if (vif.frame_tick) begin
                if (have_ft) begin
                    vectors++;
                    if (edge_cnt - ft_edge != FRAME) begin
                        miscompares++;
                        $display("FAIL tick_period: got %0d clocks, want %0d", edge_cnt - ft_edge, FRAME);
                    end
                end
                have_ft = 1; ft_edge = edge_cnt;
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        prev_i = '0;
        prev_j = '0;
        reset = 1'b1;
        vif.VGA_R_in = 8'h00;
        vif.VGA_G_in = 8'h00;
        vif.VGA_B_in = 8'h00;
        repeat (4) @(negedge VGA_CLK);
        check_reset("power_on");

        reset = 1'b0;
        run(FRAME + 500, M_RAND);
        $display("phase random: %0d vectors, %0d miscompares", vectors, miscompares);
        run(FRAME, M_PROD);
        $display("phase producer: %0d vectors, %0d miscompares", vectors, miscompares);
        run(FRAME, M_FF);
        $display("phase constant_ff: %0d vectors, %0d miscompares", vectors, miscompares);

        for (int k = 0; k < FRAME && (edge_cnt % FRAME) != RST_TARGET; k++) run(1, M_RAND);
        #1 reset = 1'b1;
        #1 check_reset("mid_assert");
        exp_q.delete();
        repeat (5) begin
            @(posedge VGA_CLK);
            #1 check_reset("mid_hold");
        end
        @(negedge VGA_CLK);
        reset = 1'b0;
        prev_i = '0;
        prev_j = '0;
        run(FRAME + 300, M_RAND);
        $display("phase after_reset: %0d vectors, %0d miscompares", vectors, miscompares);

        @(negedge VGA_CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
